// File: rtl/dsp_arbiter.sv
// dsp_arbiter
// Shares one bank of DSP multiplier lanes between NUM_REQ requesters.
// A round-robin arbiter with a burst cap picks one owner at a time. The
// owner's operands and clock enable are muxed onto the bank. A tag pipeline
// that matches the DSP latency sends each product back to the requester
// that issued it, even after the grant has moved on.
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   req         per-requester request, held high for the whole burst
//   ce_in       per-requester DSP enable, honoured only while granted
//   a_in, b_in  per-requester operands, NUM_REQ x LANES x 18, requester 0 in the LSBs
//   gnt         registered one-hot grant, or all zero
//   owner       index of the current grantee (valid only when gnt != 0)
//   res_out     DSP products broadcast to all requesters, LANES x 37
//   res_valid   one-hot; marks res_out as belonging to requester i this cycle
//   dsp_a0/b0   operands driven to the DSP bank, LANES x 18
//   dsp_ce      DSP bank clock enable
//   dsp_out     DSP bank products, LANES x 37
module dsp_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int LANES     = 5,
  parameter int DSP_LAT   = 1,
  parameter int MAX_BURST = 64,
  localparam int OWN_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         ce_in,
  input  logic [NUM_REQ*LANES*18-1:0] a_in,
  input  logic [NUM_REQ*LANES*18-1:0] b_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [LANES*37-1:0]        res_out,
  output logic [NUM_REQ-1:0]         res_valid,
  output logic [OWN_W-1:0]           owner,
  output logic [LANES*18-1:0]        dsp_a0,
  output logic [LANES*18-1:0]        dsp_b0,
  output logic                       dsp_ce,
  input  logic [LANES*37-1:0]        dsp_out
);

  localparam int OPW    = LANES * 18;
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam int LAST   = DSP_LAT - 1;

  typedef enum logic {G_NONE, G_HELD} gstate_e;

  gstate_e            state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   ptr_q, ptr_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;

  logic               tag_v_q   [DSP_LAT];
  logic               tag_v_d   [DSP_LAT];
  logic [OWN_W-1:0]   tag_own_q [DSP_LAT];
  logic [OWN_W-1:0]   tag_own_d [DSP_LAT];

  logic [NUM_REQ-1:0] cand;
  logic               pick_found;
  logic [OWN_W-1:0]   pick_idx;
  logic [OWN_W-1:0]   pick_nxt;
  logic               at_cap;
  logic               keep;

  // Round-robin search. While a grant is held, the owner is removed from the
  // candidates. ptr is always owner+1 at that point, so one search from ptr
  // covers two cases: the voluntary release and the forced hand-over at the
  // burst cap.
  // NOTE: every variable of a combinational block gets a default before any
  // conditional write, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : search_c
    int idx;
    cand = req;
    if (state_q == G_HELD) cand[owner_q] = 1'b0;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && cand[OWN_W'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = OWN_W'(idx);
      end
    end
    pick_nxt = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
  end

  always_comb begin : next_c
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;

    at_cap = (bcnt_q == BCNT_W'(MAX_BURST));
    // The owner keeps the bank while it still requests, unless the cap is
    // reached and someone else is waiting.
    keep = (state_q == G_HELD) && req[owner_q] && (!at_cap || !pick_found);

    if (keep) begin
      if (!at_cap) bcnt_d = bcnt_q + 1'b1;
    end else if (pick_found) begin
      state_d         = G_HELD;
      gnt_d           = '0;
      gnt_d[pick_idx] = 1'b1;
      owner_d         = pick_idx;
      ptr_d           = pick_nxt;
      bcnt_d          = BCNT_W'(1);
    end else begin
      // Released with nobody waiting. ptr keeps its value.
      state_d = G_NONE;
      gnt_d   = '0;
      bcnt_d  = '0;
    end
  end

  // The operand mux is driven straight from the registered grant, so an
  // ungranted requester's ce_in never reaches the bank.
  always_comb begin : mux_c
    dsp_a0 = '0;
    dsp_b0 = '0;
    dsp_ce = 1'b0;
    if (state_q == G_HELD) begin
      dsp_a0 = a_in[int'(owner_q)*OPW +: OPW];
      dsp_b0 = b_in[int'(owner_q)*OPW +: OPW];
      dsp_ce = ce_in[owner_q];
    end
  end

  // Each tag stage records who issued the DSP operation in that slot.
  always_comb begin : tag_c
    tag_v_d[0]   = dsp_ce;
    tag_own_d[0] = owner_q;
    for (int s = 1; s < DSP_LAT; s++) begin
      tag_v_d[s]   = tag_v_q[s-1];
      tag_own_d[s] = tag_own_q[s-1];
    end
  end

  always_comb begin : res_c
    res_valid = '0;
    if (tag_v_q[LAST]) res_valid[tag_own_q[LAST]] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the value from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= G_NONE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      for (int s = 0; s < DSP_LAT; s++) tag_v_q[s] <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      for (int s = 0; s < DSP_LAT; s++) tag_v_q[s] <= tag_v_d[s];
    end
  end

  // NOTE: only the tag valid bits need reset. The owner fields are ignored
  // while their valid bit is low, so these flops are left without reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < DSP_LAT; s++) tag_own_q[s] <= tag_own_d[s];
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign res_out = dsp_out;

endmodule

// File: doc/dsp_arbiter.md
# dsp_arbiter

Shares the NPU's bank of DSP multiplier lanes between several requesters, for example the matrix multiplier and a second compute unit. Each requester drives its own operand, clock-enable and request signals. The block grants the bank to one requester at a time using round-robin with a burst cap, muxes the granted operands onto the DSP inputs, and routes each result back to the requester that issued it. Grants can change while results are still in flight in the DSP pipeline.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- LANES, 5: DSP lanes in the bank.
- DSP_LAT, 1: cycles from `dsp_ce` sampled high to the matching `dsp_out`, 1..4.
- MAX_BURST, 64: maximum consecutive granted cycles while another requester is waiting, ≥ 1.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  NUM_REQ  per-requester request; held high for the whole burst.
- ce_in  in  NUM_REQ  per-requester DSP enable; honoured only while granted.
- a_in  in  NUM_REQ×LANES×18  per-requester A operands.
- b_in  in  NUM_REQ×LANES×18  per-requester B operands.
- gnt  out  NUM_REQ  registered one-hot grant, or all zero.
- res_out  out  LANES×37  `dsp_out`, broadcast to all requesters.
- res_valid  out  NUM_REQ  one-hot; marks `res_out` as belonging to requester i this cycle.
- owner  out  clog2(NUM_REQ)  index of the current grantee; meaningful only when `gnt` is non-zero.
- dsp_a0  out  LANES×18  A operands to the DSP bank.
- dsp_b0  out  LANES×18  B operands to the DSP bank.
- dsp_ce  out  1  DSP clock enable.
- dsp_out  in  LANES×37  DSP products.

## Operation
- Registered state:
  - grant register (`gnt`, `owner`)
  - round-robin pointer `ptr`: the index with highest priority in the next arbitration
  - burst counter `bcnt`, saturating at MAX_BURST
  - tag pipeline of DSP_LAT stages, each stage {valid, owner}
- Per-requester state is IDLE, WAIT (req high, not granted) or GRANTED. Grant state is NONE or HELD(i).
- Arbitration is evaluated every cycle; the result is registered into `gnt`.
  - NONE, any req high → HELD(j), where j is the first requester with req high searching from `ptr` upward with wrap-around. `bcnt` becomes 1.
  - HELD(i), req[i] low → the arbitration result. This is NONE if nobody else is requesting. Handover to another requester takes no idle cycle.
  - HELD(i), req[i] high, `bcnt` < MAX_BURST or no other req high → hold. `bcnt` increments, saturating.
  - HELD(i), `bcnt` == MAX_BURST and another req high → forced to the next requester searched from i+1.
  - On every grant change, `ptr` becomes new owner + 1 (mod NUM_REQ). With no grant, `ptr` is unchanged.
- Datapath, combinational from the registered grant:
  - While HELD(i): `dsp_a0` = a_in[i], `dsp_b0` = b_in[i], `dsp_ce` = ce_in[i].
  - While NONE: `dsp_a0` and `dsp_b0` are 0 and `dsp_ce` is 0.
- `ce_in` from an ungranted requester has no effect on any output.
- Tag pipeline: stage 0 captures {`dsp_ce`, `owner`} every cycle. At the last stage, valid v with owner k drives `res_valid[k]` = v. `res_out` = `dsp_out` unmodified, with no width change or saturation.
- In-flight results are always delivered to their issuer, even after the grant has moved on.
- Requesters must sample `gnt` and stop relying on the bank in the cycle `gnt` falls. An operand presented while `gnt` is low is never multiplied.

## Timing
- Reset values:
  - `gnt` = 0, `owner` = 0, `ptr` = 0, `bcnt` = 0.
  - Tag pipeline all invalid, so `res_valid` = 0.
  - `dsp_ce` = 0 and `dsp_a0` = `dsp_b0` = 0.
- Asserting `rst` mid-burst clears everything on the next edge. In-flight results are discarded: `res_valid` stays 0 for them.
- Grant latency:
  - req rising at edge t (bank free) → `gnt` high after edge t+1.
  - Owner's req falling before edge t → `gnt` low after edge t; a waiting requester is granted at that same edge.
- Result latency: `dsp_ce` high in cycle n → `res_valid` high in cycle n+DSP_LAT for exactly one cycle.
- Throughput: one issue per cycle per bank. Switching grant costs 0 bubble cycles.
- Simultaneous events:
  - All requesters rise together after reset → requester 0 wins.
  - Owner drops req in the same cycle its burst cap expires → normal release rule applies, with the same outcome.
- With NUM_REQ = 1, the burst cap never forces a release.

## Test plan
- Single requester, DSP_LAT=1: req0 at cycle 0 → `gnt`=01 at cycle 1; lane0 a=3, b=5 with ce_in[0] high in cycle 2 → `res_valid`=01 in cycle 3 and `res_out` lane0 = 15.
- req0 and req1 both rise in the first cycle after reset → `gnt`=01; drop req0 at cycle 5 → `gnt`=10 at cycle 6 with no all-zero cycle; `ptr` = 0 afterwards.
- MAX_BURST=4, both req held high → `gnt` alternates 01, 10 every 4 cycles for 32 cycles, with no idle cycles.
- DSP_LAT=2: owner 0 issues a=7, b=9 on its last granted cycle, owner 1 issues a=2, b=100 on its first → `res_valid[0]` with 63, then `res_valid[1]` with 200, on consecutive cycles.
- While HELD(0), requester 1 drives ce_in[1]=1 with a=b=255 → `dsp_ce` and `dsp_a0` follow requester 0 only; `res_valid[1]` never rises.
- Assert `rst` mid-burst with 2 results in flight → `gnt`, `dsp_ce` and `res_valid` are 0 from the next edge; after release, simultaneous requests grant requester 0.
